wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Consumer end of the Memory-Access→WriteBack pipeline register.
- Selects and formats the writeback result: ALU result, load data (sub-word aligned and extended), or PC+4.
- Commits that result to the 32×32 integer register file and serves the two Decode-stage read ports.
- Also keeps a 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, architectural register count; x0 is hardwired to zero.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- ValidW  input  1  a real (non-bubble) instruction occupies WB this cycle
- RegWriteW  input  1  instruction writes Rd
- ResultSrcW  input  2  result select: 00 ALU, 01 load, 10 PC+4, 11 reserved
- Funct3W  input  3  load size/sign code
- ALUResultW  input  XLEN  ALU result / load effective address
- ReadDataW  input  XLEN  raw aligned word from data memory
- RdW  input  5  destination register
- PCPlus4W  input  XLEN  link value
- Rs1D  input  5  Decode read address 1
- Rs2D  input  5  Decode read address 2
- RD1D  output  XLEN  read data 1
- RD2D  output  XLEN  read data 2
- ResultW  output  XLEN  formatted writeback value, also used by the forwarding unit
- InstretW  output  CNT_W  retired-instruction count

Behaviour:
- Reset (synchronous, active-high, on posedge with reset=1):
  - All registers x1..x31 are cleared to 0; InstretW is cleared to 0.
  - Reset has priority over a write or count increment in the same cycle.
  - Reset asserted mid-stream discards any pending write.
- ResultW is combinational, with no latency:
  - 00 → ALUResultW
  - 01 → extended load
  - 10 → PCPlus4W
  - 11 → ALUResultW
- Load extension; off = ALUResultW[1:0]:
  - Funct3 000 (LB): sign-extend ReadDataW byte[off].
  - 100 (LBU): zero-extend byte[off].
  - 001 (LH): sign-extend halfword[off[1]].
  - 101 (LHU): zero-extend halfword[off[1]].
  - 010 (LW): full word.
  - Other codes: full word.
  - Misalignment is not detected here. LH with off=3 uses halfword[1].
- Register write:
  - Occurs at posedge when RegWriteW && ValidW && RdW≠0; writes ResultW to x[RdW].
  - Writes to x0 are ignored.
  - RegWriteW with ValidW=0 performs no write.
- Reads are combinational: RD1D = x[Rs1D] and RD2D = x[Rs2D]. x0 always reads 0.
- Same-cycle write and read of the same register: behaviour depends on RF_BYPASS_EN (see Optional Feature).
- Retired-instruction counter:
  - InstretW increments by 1 on each posedge with ValidW=1, independent of RegWriteW.
  - It wraps from all-ones to 0 with no flag.
- Rs1D == Rs2D == RdW: both ports behave identically.

Optional Feature:
- Macro: WB_REGFILE_BYPASS_EN.
- Defined: a read port whose address equals RdW, during a qualifying write (RegWriteW && ValidW && RdW≠0), returns ResultW combinationally in the same cycle. The hazard unit needs no WB→D stall.
- Undefined: read ports return the stored (old) value until the posedge commits. The hazard unit must stall Decode one cycle on an Rs==RdW match with WB.

Decomposition:
- Shared package riscv_pkg:
  - XLEN and NREGS constants.
  - ResultSrc encodings: RES_ALU, RES_LOAD, RES_PC4.
  - Load funct3 codes: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
- Sub-module load_extend: purely combinational; inputs ReadDataW, off[1:0], Funct3W; output 32-bit extended data.
- Register array, write logic, read/bypass muxes and counter stay in wb_regfile.

Test Plan:
- Reset: write x5=0x1234 and release; assert reset for 1 cycle → x5 reads 0, InstretW=0. Reset and a write in the same cycle → no write occurs.
- Load extension: ReadDataW=0x80FF7F01, LB at offsets 0/1/2/3 → 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80.
  - LBU at offset 3 → 0x00000080.
  - LH at offset 2 → 0xFFFF80FF.
  - LHU at offset 0 → 0x00007F01.
- Result select: ALUResultW=0xA, PCPlus4W=0x104. Select 10 → ResultW=0x104; select 11 → 0xA. Write to x1 → next cycle RD1D(Rs1D=1)=0x104.
- x0 and ValidW gating: write 0xDEAD to RdW=0 → RD1D(0)=0. RegWriteW=1 with ValidW=0 targeting x3 → x3 unchanged and InstretW unchanged.
- Bypass: write x7=0x55 while Rs1D=7 in the same cycle → RD1D=0x55 combinationally with the macro defined. Without it, RD1D shows the old value, then 0x55 after the posedge.
- Counter: 5 cycles of ValidW=1 → InstretW=5. Force a preset of 0xFFFF_FFFF_FFFF_FFFF via hierarchical deposit, then one ValidW=1 cycle → 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V constants: datapath sizes, result-select codes, load funct3 codes.
// Imported by the writeback stage and its load formatter.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } res_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_regfile_load_extend.sv
// Load formatter: selects the addressed byte/halfword of the memory word
// and sign- or zero-extends it. Misaligned offsets are not flagged.
import riscv_pkg::*;

module load_extend (
    input  logic [31:0] ReadDataW,
    input  logic [1:0]  off,
    input  logic [2:0]  Funct3W,
    output logic [31:0] ExtDataW
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword lane
    always_comb begin
        byte_sel = ReadDataW[7:0];
        case (off)
            2'd0:    byte_sel = ReadDataW[7:0];
            2'd1:    byte_sel = ReadDataW[15:8];
            2'd2:    byte_sel = ReadDataW[23:16];
            default: byte_sel = ReadDataW[31:24];
        endcase
        half_sel = off[1] ? ReadDataW[31:16]
                          : ReadDataW[15:0];
    end

    // Extend according to the load size/sign code
    always_comb begin
        ExtDataW = ReadDataW;
        case (Funct3W)
            F3_LB:   ExtDataW = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  ExtDataW = {24'd0, byte_sel};
            F3_LH:   ExtDataW = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  ExtDataW = {16'd0, half_sel};
            default: ExtDataW = ReadDataW;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: formats the result, commits it to the integer register
// file, serves the two Decode read ports and counts retired instructions.
// Optional macro WB_REGFILE_BYPASS_EN: same-cycle write-to-read forwarding.
import riscv_pkg::*;

module wb_regfile #(
    parameter int XLEN_P  = XLEN,
    parameter int NREGS_P = NREGS,
    parameter int CNT_W   = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ValidW,
    input  logic               RegWriteW,
    input  logic [1:0]         ResultSrcW,
    input  logic [2:0]         Funct3W,
    input  logic [XLEN_P-1:0]  ALUResultW,
    input  logic [XLEN_P-1:0]  ReadDataW,
    input  logic [4:0]         RdW,
    input  logic [XLEN_P-1:0]  PCPlus4W,
    input  logic [4:0]         Rs1D,
    input  logic [4:0]         Rs2D,
    output logic [XLEN_P-1:0]  RD1D,
    output logic [XLEN_P-1:0]  RD2D,
    output logic [XLEN_P-1:0]  ResultW,
    output logic [CNT_W-1:0]   InstretW
);

    logic [XLEN_P-1:0] rf_q [NREGS_P];
    logic [CNT_W-1:0]  instret_q;
    logic [CNT_W-1:0]  instret_d;
    logic [XLEN_P-1:0] load_data;
    logic              wr_en;

    load_extend u_load_extend (
        .ReadDataW (ReadDataW),
        .off       (ALUResultW[1:0]),
        .Funct3W   (Funct3W),
        .ExtDataW  (load_data)
    );

    // Writeback result select; the reserved code falls back to the ALU
    always_comb begin
        ResultW = ALUResultW;
        case (ResultSrcW)
            RES_LOAD: ResultW = load_data;
            RES_PC4:  ResultW = PCPlus4W;
            default:  ResultW = ALUResultW;
        endcase
    end

    assign wr_en = RegWriteW && ValidW && (RdW != 5'd0);

    // Commit the result; reset wipes the whole file and wins over a write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS_P; i++)
                rf_q[i] <= '0;
        end else if (wr_en) begin
            rf_q[RdW] <= ResultW;
        end
    end

    // Read port 1: x0 is zero, optional forwarding of the in-flight write
    always_comb begin
        RD1D = (Rs1D == 5'd0) ? '0 : rf_q[Rs1D];
`ifdef WB_REGFILE_BYPASS_EN
        if (wr_en && (Rs1D == RdW))
            RD1D = ResultW;
`endif
    end

    // Read port 2: identical behaviour to port 1
    always_comb begin
        RD2D = (Rs2D == 5'd0) ? '0 : rf_q[Rs2D];
`ifdef WB_REGFILE_BYPASS_EN
        if (wr_en && (Rs2D == RdW))
            RD2D = ResultW;
`endif
    end

    // Retired count advances on every real instruction and wraps silently
    always_comb begin
        instret_d = instret_q;
        if (ValidW)
            instret_d = instret_q + 1'b1;
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset)
            instret_q <= '0;
        else
            instret_q <= instret_d;
    end

    assign InstretW = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile with a per-cycle reference model.
// Honours WB_REGFILE_BYPASS_EN for the same-cycle read expectation.
module tb_wb_regfile;

    logic        clk = 0;
    logic        reset;
    logic        ValidW, RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [2:0]  Funct3W;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RdW, Rs1D, Rs2D;
    logic [31:0] RD1D, RD2D, ResultW;
    logic [63:0] InstretW;

    int vectors = 0;
    int miscompares = 0;
    bit checking = 0;

    bit [31:0] m_rf [32];
    bit [63:0] m_cnt;

    wb_regfile dut (
        .clk        (clk),
        .reset      (reset),
        .ValidW     (ValidW),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .Funct3W    (Funct3W),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .RdW        (RdW),
        .PCPlus4W   (PCPlus4W),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .RD1D       (RD1D),
        .RD2D       (RD2D),
        .ResultW    (ResultW),
        .InstretW   (InstretW)
    );

    always #5 clk = ~clk;

    function automatic bit [31:0] m_load();
        bit [31:0] b, h;
        int sh;
        sh = int'(ALUResultW[1:0]) * 8;
        b = (ReadDataW >> sh) & 32'hFF;
        h = ALUResultW[1] ? (ReadDataW >> 16) : (ReadDataW & 32'hFFFF);
        h = h & 32'hFFFF;
        case (Funct3W)
            3'b000: return (b > 127) ? b - 256 : b;
            3'b100: return b;
            3'b001: return (h > 32767) ? h - 65536 : h;
            3'b101: return h;
            default: return ReadDataW;
        endcase
    endfunction

    function automatic bit [31:0] m_res();
        if (ResultSrcW == 2'b01) return m_load();
        if (ResultSrcW == 2'b10) return PCPlus4W;
        return ALUResultW;
    endfunction

    function automatic bit m_we();
        return RegWriteW && ValidW && RdW != 0;
    endfunction

    function automatic bit [31:0] m_rd(input bit [4:0] a);
        if (a == 0) return 0;
`ifdef WB_REGFILE_BYPASS_EN
        if (m_we() && a == RdW) return m_res();
`endif
        return m_rf[a];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            foreach (m_rf[i]) m_rf[i] = 0;
            m_cnt = 0;
        end else begin
            if (m_we()) m_rf[RdW] = m_res();
            if (ValidW) m_cnt = m_cnt + 1;
        end
    end

    task automatic chk(input string n,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("model_rd1", {32'd0, RD1D}, {32'd0, m_rd(Rs1D)});
            chk("model_rd2", {32'd0, RD2D}, {32'd0, m_rd(Rs2D)});
            chk("model_res", {32'd0, ResultW}, {32'd0, m_res()});
            chk("model_cnt", InstretW, m_cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w,
                         input logic [1:0] s, input logic [2:0] f,
                         input logic [31:0] alu, input logic [31:0] rd,
                         input logic [4:0] d, input logic [31:0] pc);
        ValidW = v; RegWriteW = w; ResultSrcW = s; Funct3W = f;
        ALUResultW = alu; ReadDataW = rd; RdW = d; PCPlus4W = pc;
    endtask

    task automatic idle();
        drive(0, 0, 2'b00, 3'b010, 0, 0, 0, 0);
    endtask

    logic [31:0] lb_exp [4] = '{32'h00000001, 32'h0000007F,
                                32'hFFFFFFFF, 32'hFFFFFF80};
    bit [63:0] cnt_before;

    initial begin
        idle();
        Rs1D = 0; Rs2D = 0;
        reset = 1;
        step();
        checking = 1;
        reset = 0;
        Rs1D = 5;
        @(negedge clk);
        chk("rst_instret", InstretW, 64'd0);
        chk("rst_x5", {32'd0, RD1D}, 64'd0);

        step();
        drive(1, 1, 2'b00, 3'b010, 32'h1234, 0, 5, 0);
        step();
        idle();
        @(negedge clk);
        chk("x5_write", {32'd0, RD1D}, 64'h1234);
        step();
        reset = 1;
        step();
        reset = 0;
        @(negedge clk);
        chk("x5_reset", {32'd0, RD1D}, 64'd0);
        chk("cnt_reset", InstretW, 64'd0);

        step();
        reset = 1;
        drive(1, 1, 2'b00, 3'b010, 32'h99, 0, 6, 0);
        step();
        reset = 0;
        idle();
        Rs2D = 6;
        @(negedge clk);
        chk("rst_wins", {32'd0, RD2D}, 64'd0);

        for (int o = 0; o < 4; o++) begin
            step();
            drive(0, 0, 2'b01, 3'b000, o, 32'h80FF7F01, 0, 0);
            @(negedge clk);
            chk($sformatf("lb_off%0d", o), {32'd0, ResultW},
                {32'd0, lb_exp[o]});
        end
        step();
        drive(0, 0, 2'b01, 3'b100, 3, 32'h80FF7F01, 0, 0);
        @(negedge clk);
        chk("lbu_off3", {32'd0, ResultW}, 64'h00000080);
        step();
        drive(0, 0, 2'b01, 3'b001, 2, 32'h80FF7F01, 0, 0);
        @(negedge clk);
        chk("lh_off2", {32'd0, ResultW}, 64'hFFFF80FF);
        step();
        drive(0, 0, 2'b01, 3'b101, 0, 32'h80FF7F01, 0, 0);
        @(negedge clk);
        chk("lhu_off0", {32'd0, ResultW}, 64'h00007F01);
        step();
        drive(0, 0, 2'b01, 3'b001, 3, 32'h80FF7F01, 0, 0);
        @(negedge clk);
        chk("lh_off3", {32'd0, ResultW}, 64'hFFFF80FF);

        step();
        drive(0, 0, 2'b11, 3'b010, 32'hA, 0, 0, 32'h104);
        @(negedge clk);
        chk("sel11", {32'd0, ResultW}, 64'hA);
        step();
        drive(1, 1, 2'b10, 3'b010, 32'hA, 0, 1, 32'h104);
        Rs1D = 1;
        @(negedge clk);
        chk("sel10", {32'd0, ResultW}, 64'h104);
        step();
        idle();
        @(negedge clk);
        chk("x1_pc4", {32'd0, RD1D}, 64'h104);

        step();
        drive(1, 1, 2'b00, 3'b010, 32'hDEAD, 0, 0, 0);
        Rs1D = 0;
        step();
        idle();
        @(negedge clk);
        chk("x0_zero", {32'd0, RD1D}, 64'd0);

        cnt_before = m_cnt;
        step();
        drive(0, 1, 2'b00, 3'b010, 32'h77, 0, 3, 0);
        Rs2D = 3;
        step();
        idle();
        @(negedge clk);
        chk("x3_novalid", {32'd0, RD2D}, 64'd0);
        chk("cnt_novalid", InstretW, cnt_before);

        step();
        drive(1, 1, 2'b00, 3'b010, 32'h11, 0, 7, 0);
        step();
        drive(1, 1, 2'b00, 3'b010, 32'h55, 0, 7, 0);
        Rs1D = 7;
        Rs2D = 7;
        @(negedge clk);
`ifdef WB_REGFILE_BYPASS_EN
        chk("bypass_rd1", {32'd0, RD1D}, 64'h55);
`else
        chk("nobypass_rd1", {32'd0, RD1D}, 64'h11);
`endif
        step();
        idle();
        @(negedge clk);
        chk("x7_commit", {32'd0, RD1D}, 64'h55);
        chk("x7_rd2", {32'd0, RD2D}, 64'h55);

        step();
        reset = 1;
        step();
        reset = 0;
        ValidW = 1;
        repeat (5) step();
        ValidW = 0;
        @(negedge clk);
        chk("cnt5", InstretW, 64'd5);

        #1;
        dut.instret_q = '1;
        m_cnt = '1;
        ValidW = 1;
        step();
        ValidW = 0;
        @(negedge clk);
        chk("cnt_wrap", InstretW, 64'd0);

        step();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
